scroll_band: RTL

Parametrised, horizontally scrolling background band for the VGA playfield (grass strip, tree line, cloud layer). For each pixel it flags band membership and emits a texture ROM address, tiling a power-of-two-wide texture horizontally with a per-frame, sub-pixel scroll offset. It sits between the VGA controller (DrawX/DrawY) and the color mapper / band texture ROM. Several instances with different parameters stack into a parallax background.

---
 rtl/scroll_band.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/scroll_band.sv
// scroll_band: horizontally scrolling, power-of-two tiled background band.
//
// For every pixel it flags band membership and emits a texture ROM address
// {row, col}. The texture tiles every 2^W_LOG2 columns and is shifted by a
// sub-pixel offset that advances once per frame. Several instances with
// different parameters can be stacked into a parallax background.
//
// Build option:
//   LAYER_SCROLL_EN - when defined, the frame_clk synchroniser, the offset
//                     accumulator and frame_tick are compiled in. When
//                     undefined, the offset is fixed at 0, frame_tick is tied
//                     low and speed/dir/pause/frame_clk are ignored.
//
// Ports:
//   Clk        in   system clock (50 MHz)
//   Reset      in   asynchronous, active-high reset
//   frame_clk  in   frame strobe (~60 Hz), asynchronous to Clk
//   DrawX      in   current pixel column
//   DrawY      in   current pixel row
//   speed      in   unsigned scroll speed in 1/2^FRAC px per frame
//   dir        in   0: texture moves left, 1: texture moves right
//   pause      in   freezes the offset while high (sampled on frame_tick)
//   is_band    out  pixel belongs to the band (registered)
//   band_addr  out  texture ROM address {row, col}, 0 outside the band
//   frame_tick out  one-Clk pulse per detected frame_clk rising edge

module scroll_band #(
    parameter logic [9:0] BAND_Y   = 10'd245,
    parameter int         H_LOG2   = 6,
    parameter int         W_LOG2   = 8,
    parameter logic [9:0] SCREEN_W = 10'd640,
    parameter int         FRAC     = 4,
    parameter int         SPD_W    = 8
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       frame_clk,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    input  logic [SPD_W-1:0]           speed,
    input  logic                       dir,
    input  logic                       pause,
    output logic                       is_band,
    output logic [H_LOG2+W_LOG2-1:0]   band_addr,
    output logic                       frame_tick
);

    localparam int          AW     = H_LOG2 + W_LOG2;
    localparam int          ACC_W  = W_LOG2 + FRAC;
    localparam logic [10:0] BAND_H = 11'd1 << H_LOG2;

    // Integer part of the scroll offset, in texture columns.
    logic [W_LOG2-1:0] off_s;

`ifdef LAYER_SCROLL_EN
    logic             sync1_q;
    logic             sync2_q;
    logic             edge_q;
    logic             tick_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] spd_ext_s;

    assign spd_ext_s  = ACC_W'(speed);
    assign off_s      = acc_q[ACC_W-1:FRAC];
    assign frame_tick = tick_q;

    // Synchronise frame_clk and turn its rising edge into a single-cycle tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
            tick_q  <= sync2_q & ~edge_q;
        end
    end

    // Next offset: speed/dir/pause only matter on a tick; wrap is modular.
    always_comb begin
        acc_d = acc_q;
        if (tick_q && !pause) begin
            if (dir) begin
                acc_d = acc_q - spd_ext_s;
            end else begin
                acc_d = acc_q + spd_ext_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Offset accumulator register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    // Scroll inputs are intentionally unused in the static build.
    logic unused_scroll_s;
    assign unused_scroll_s = ^{frame_clk, dir, pause, speed};
    assign off_s           = '0;
    assign frame_tick      = 1'b0;
`endif

    // Pixel path: 11-bit row difference keeps BAND_Y + 2^H_LOG2 from overflowing.
    logic [10:0]       dy_diff_s;
    logic [W_LOG2-1:0] col_s;
    logic              is_band_d;
    logic [AW-1:0]     addr_d;
    logic              is_band_q;
    logic [AW-1:0]     addr_q;

    assign dy_diff_s = {1'b0, DrawY} - {1'b0, BAND_Y};
    // Column wraps for free by keeping only W_LOG2 bits of the sum.
    assign col_s     = W_LOG2'(DrawX) + off_s;

    // Membership test and address formation.
    always_comb begin
        is_band_d = 1'b0;
        addr_d    = '0;
        if ((DrawY >= BAND_Y) && (dy_diff_s < BAND_H) && (DrawX < SCREEN_W)) begin
            is_band_d = 1'b1;
            addr_d    = {dy_diff_s[H_LOG2-1:0], col_s};
        end else begin
            is_band_d = 1'b0;
            addr_d    = '0;
        end
    end

    // Output pipeline stage.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            is_band_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            is_band_q <= is_band_d;
            addr_q    <= addr_d;
        end
    end

    assign is_band   = is_band_q;
    assign band_addr = addr_q;

endmodule
